// File: rtl/clint_timer.sv
// clint_timer -- memory-mapped machine timer (mtime / mtimecmp) for the CLINT.
//
// mtime advances once every TICK_DIV clk cycles through a prescaler. The LSU
// reaches mtime/mtimecmp through a single-beat valid/ready request/response
// handshake. timer_int_o is a registered level of (mtime >= mtimecmp).
//
// Optional feature: define CLINT_MSIP_EN to add the msip register at offset
// 0x0000 and the soft_int_o output. Without it, offset 0x0000 is unmapped.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_wen_i, req_addr_i         1 = write; byte address, bits [2:0] ignored
//   req_wdata_i, req_wmask_i      write data and per-byte enables
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o        read data (0 for writes/errors), unmapped flag
//   mtime_o                       current mtime
//   soft_int_o                    msip[0] (CLINT_MSIP_EN only)
//   timer_int_o                   machine timer interrupt pending (level)
//
// Handshake FSM:
//   state  | meaning
//   S_IDLE | ready for a request; an accepted access executes this cycle
//   S_RESP | response held on rsp_* until rsp_ready_i
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [63:0] mtime_o,
`ifdef CLINT_MSIP_EN
    output logic        soft_int_o,
`endif
    output logic        timer_int_o
);

    localparam logic [63:0] CMP_ADDR   = BASE_ADDR + 64'h4000;
    localparam logic [63:0] MTIME_ADDR = BASE_ADDR + 64'hBFF8;
    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t      state;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [15:0] presc_q;
    logic        ready_q;
    logic        valid_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic        int_q;

    logic        accept;
    logic        sel_cmp;
    logic        sel_mtime;
    logic        sel_err;
    logic        tick;
    logic        wr_mtime;
    logic        wr_cmp;
    logic [63:0] bmask;
    logic [63:0] rd_val;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[2:0];

    assign accept    = (state == S_IDLE) && ready_q && req_valid_i;
    assign sel_cmp   = (req_addr_i[63:3] == CMP_ADDR[63:3]);
    assign sel_mtime = (req_addr_i[63:3] == MTIME_ADDR[63:3]);
    assign tick      = (presc_q == TICK_LAST);

`ifdef CLINT_MSIP_EN
    logic msip_q;
    logic sel_msip;
    logic wr_msip;

    assign sel_msip   = (req_addr_i[63:3] == BASE_ADDR[63:3]);
    assign sel_err    = !(sel_cmp || sel_mtime || sel_msip);
    assign wr_msip    = accept && req_wen_i && sel_msip && req_wmask_i[0];
    assign soft_int_o = msip_q;
`else
    assign sel_err = !(sel_cmp || sel_mtime);
`endif

    // A zero-mask write to mtime is a pure no-op, so it must not disturb
    // the prescaler either.
    assign wr_mtime = accept && req_wen_i && sel_mtime && (req_wmask_i != 8'h00);
    assign wr_cmp   = accept && req_wen_i && sel_cmp;

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 8; i++) begin
            bmask[8*i +: 8] = {8{req_wmask_i[i]}};
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_cmp) begin
            rd_val = mtimecmp_q;
        end else if (sel_mtime) begin
            rd_val = mtime_q;
        end
`ifdef CLINT_MSIP_EN
        else if (sel_msip) begin
            rd_val = {63'd0, msip_q};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            int_q      <= 1'b0;
`ifdef CLINT_MSIP_EN
            msip_q     <= 1'b0;
`endif
        end else begin
            int_q <= (mtime_q >= mtimecmp_q);

            // Software write to mtime beats a coincident tick and restarts
            // the prescaler.
            if (wr_mtime) begin
                mtime_q <= (mtime_q & ~bmask) | (req_wdata_i & bmask);
                presc_q <= '0;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 16'd1;
            end

            if (wr_cmp) begin
                mtimecmp_q <= (mtimecmp_q & ~bmask) | (req_wdata_i & bmask);
            end
`ifdef CLINT_MSIP_EN
            if (wr_msip) begin
                msip_q <= req_wdata_i[0];
            end
`endif

            if (state == S_IDLE) begin
                ready_q <= !accept;
                if (accept) begin
                    state   <= S_RESP;
                    valid_q <= 1'b1;
                    err_q   <= sel_err;
                    rdata_q <= (sel_err || req_wen_i) ? 64'd0 : rd_val;
                end
            end else if (rsp_ready_i) begin
                state   <= S_IDLE;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mtime_o     = mtime_q;
    assign timer_int_o = int_q;

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer for the core-local interruptor. It holds `mtime` and `mtimecmp`, advances `mtime` through a programmable prescaler, and serves single-beat load/store requests from the LSU via a valid/ready request/response handshake. It drives the registered `timer_int_o` level that feeds the CLINT's `timer_int_i`, so it is the block that configures and sequences timer interrupts for the core.

## Interface
- `BASE_ADDR`, 64'h0000_0000_0200_0000, base of the timer region.
- `TICK_DIV`, 1, `mtime` increments once every `TICK_DIV` clk cycles. Legal range 1..65535.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_wen_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  64  byte address; bits [2:0] ignored (doubleword access).
- `req_wdata_i`  in  64  write data.
- `req_wmask_i`  in  8  byte write enables; bit n covers bits [8n+7:8n].
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_rdata_o`  out  64  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  unmapped address.
- `mtime_o`  out  64  current `mtime`.
- `timer_int_o`  out  1  machine timer interrupt pending (level).

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x4000: `mtimecmp`, reset all-ones.
  - 0xBFF8: `mtime`, reset 0.
  - Any other address: error.
- Handshake FSM, two states:
  - IDLE: `req_ready_o`=1. When `req_valid_i` is high, the request is accepted, the access executes in that cycle, and the FSM moves to RESP.
  - RESP: `req_ready_o`=0 and `rsp_valid_o`=1. Response fields stay stable until `rsp_ready_i` is high, then the FSM returns to IDLE. No back-to-back acceptance in the cycle where the response is consumed.
- Reads return the register value in the acceptance cycle, before that cycle's tick.
- Writes merge per byte under `req_wmask_i`. A mask of 0 is a legal no-op with a normal response.
- Error access: no register changes, `rsp_err_o`=1, `rsp_rdata_o`=0.
- Prescaler counter runs 0..`TICK_DIV`-1. In the cycle it equals `TICK_DIV`-1, it wraps to 0 and `mtime` increments. When `TICK_DIV`=1, `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0. There is no sticky overflow.
- Software write to `mtime` in the same cycle as a tick: the merged write value wins, the tick is dropped, and the prescaler clears to 0.
- Software write to `mtimecmp` has no effect on `mtime` or the prescaler.
- `timer_int_o` is a register loaded every cycle with (`mtime` >= `mtimecmp`), an unsigned 64-bit compare on current register values. It is level, not pulse; the only way to clear it is to raise `mtimecmp` or lower `mtime`.

## Timing
- Reset values: `req_ready_o`=0 in the reset cycle, then 1; `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mtime_o`=0, `timer_int_o`=0; FSM is IDLE; prescaler is 0.
- Reset asserted mid-transaction: the pending response is dropped, no partial write is retained, and all registers take reset values.
- Request-to-response latency: `rsp_valid_o` rises on the clk edge following acceptance, i.e. 1 cycle.
- Write visibility: the new register value appears on `mtime_o` 1 cycle after acceptance. `timer_int_o` reflects it 1 cycle later, 2 cycles after acceptance.
- `timer_int_o` lags the compare condition by exactly 1 cycle.
- Throughput: at most 1 request per 2 cycles.

## Configuration
- `CLINT_MSIP_EN` defined:
  - Adds output `soft_int_o` (1 bit, reset 0).
  - Adds an `msip` register at offset 0x0000. Only bit 0 is writable, and only when `req_wmask_i[0]`=1; the other bits read 0.
  - `soft_int_o` equals `msip[0]` with 0-cycle register-to-port delay.
- `CLINT_MSIP_EN` undefined: no `soft_int_o` port, and offset 0x0000 returns error.

## Test plan
- Reset, then `TICK_DIV`=1 and no requests for 10 cycles -> `mtime_o`=10, `timer_int_o`=0.
- Write `mtimecmp`=20 with mask 8'hFF at `mtime`=5 -> `timer_int_o` first high in the cycle after `mtime_o` reaches 20, and it stays high. A later write of `mtimecmp`=1000 drops `timer_int_o` 2 cycles after acceptance.
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE -> after 2 ticks `mtime_o`=0, and `timer_int_o` falls if `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
- Read at offset 0x1000 -> `rsp_err_o`=1, `rsp_rdata_o`=0, no register change. Hold `rsp_ready_i`=0 for 3 cycles -> response stays stable and `req_ready_o` stays 0.
- `TICK_DIV`=4: write `mtime`=100 in the tick cycle -> `mtime_o`=100, and the next increment to 101 comes 4 cycles later. Byte write with mask 8'h01 and data 8'h55 -> only bits [7:0] change.
- `CLINT_MSIP_EN` defined: write 1 to offset 0x0000 -> `soft_int_o`=1 one cycle after acceptance, and a read returns 1. Write 0 -> `soft_int_o`=0.
